// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module : adder_arb_pkg
// Shared FSM state type and round-robin pick helper for the adder sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    RESP = 2'd3
  } seq_state_t;

  localparam int MAX_R   = 32;
  localparam int MAX_IDW = 5;

  // Returns the first valid index scanning from ptr+1 modulo r, or -1 if none.
  function automatic int rr_pick(input logic [MAX_R-1:0] valid, input int ptr, input int r);
    int pick;
    int idx;
    pick = -1;
    for (int k = 1; k <= MAX_R; k++) begin
      idx = (ptr + k) % r;
      if (k <= r && pick < 0 && valid[idx[MAX_IDW-1:0]]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nbit_adder.sv
// ============================================================================
// Module : nbit_adder
// Two-phase adder: low P bits and their carry are registered; high part is
// combinational from the operands and that registered carry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nbit_adder #(
  parameter int N = 6,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [P-1:0] r_sum_lo;
  logic         r_c_lo;
  logic [P:0]   w_lo;
  logic [N-P:0] w_hi;

  assign w_lo = {1'b0, a[P-1:0]} + {1'b0, b[P-1:0]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sum_lo <= '0;
      r_c_lo   <= 1'b0;
    end else begin
      r_sum_lo <= w_lo[P-1:0];
      r_c_lo   <= w_lo[P];
    end
  end

  assign w_hi  = {1'b0, a[N-1:P]} + {1'b0, b[N-1:P]} + {{(N-P){1'b0}}, r_c_lo};
  assign sum   = {w_hi[N-P-1:0], r_sum_lo};
  assign c_out = w_hi[N-P];

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin grant; the pointer register lives in the parent.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req_valid,
  input  logic [IDW-1:0] rr_ptr,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_any
);

  logic [MAX_R-1:0] w_valid_ext;
  int               w_pick;

  always_comb begin
    w_valid_ext        = '0;
    w_valid_ext[R-1:0] = req_valid;
    w_pick             = rr_pick(w_valid_ext, int'(rr_ptr), R);
    grant_any          = (w_pick >= 0);
    grant_id           = '0;
    for (int i = 0; i < R; i++) begin
      if (w_pick == i) grant_id = IDW'(i);
    end
  end

  for (genvar gi = 0; gi < R; gi++) begin : g_grant
    assign grant[gi] = grant_any && (grant_id == IDW'(gi));
  end

endmodule

`default_nettype wire

// File: rtl/adder_rr_sequencer.sv
// ============================================================================
// Module : adder_rr_sequencer
// Shares one two-phase nbit_adder between R requesters with round-robin grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_rr_sequencer
  import adder_arb_pkg::*;
#(
  parameter  int N   = 6,
  parameter  int P   = 2,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout
);

  seq_state_t     r_state;
  seq_state_t     w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [N-1:0]   r_op_a;
  logic [N-1:0]   r_op_b;
  logic [R-1:0]   w_grant;
  logic [IDW-1:0] w_grant_id;
  logic           w_grant_any;
  logic           w_accept;
  logic [N-1:0]   w_sum;
  logic           w_cout;

  rr_arbiter #(.R(R)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_id  (w_grant_id),
    .grant_any (w_grant_any)
  );

  // Operands are held in r_op_* across PH1 and PH2 so the high part sees them stable.
  nbit_adder #(.N(N), .P(P)) u_adder (
    .clk   (clk),
    .rstn  (rstn),
    .a     (r_op_a),
    .b     (r_op_b),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_any) begin
          req_ready   = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = PH1;
        end
      end
      PH1:     w_state_nxt = PH2;
      PH2:     w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_rr_ptr  <= IDW'(R - 1);
      r_op_a    <= '0;
      r_op_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a   <= req_a[w_grant_id*N +: N];
        r_op_b   <= req_b[w_grant_id*N +: N];
        rsp_id   <= w_grant_id;
        r_rr_ptr <= w_grant_id;
      end
      if (r_state == PH2) begin
        rsp_sum   <= w_sum;
        rsp_cout  <= w_cout;
        rsp_valid <= 1'b1;
      end
      if (r_state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_sequencer.sv
// ============================================================================
// Module : tb_adder_rr_sequencer
// Directed and randomized checks of adder_rr_sequencer against a cycle model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adder_rr_sequencer;

  localparam int N   = 6;
  localparam int P   = 2;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;

  always #5 clk = ~clk;

  adder_rr_sequencer #(.N(N), .P(P), .R(R)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: idle flag, cycles left until the result shows, pending response.
  bit m_idle;
  bit m_resp;
  int m_lat;
  int m_ptr;
  int e_id, e_sum, e_cout;
  int last_pick;

  int grants[$];
  int grant_cyc[$];
  int rsp_ids[$];
  int rsp_sums[$];
  int rsp_couts[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= R; k++) begin
      int i;
      i = (m_ptr + k) % R;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    int pick;
    int a, b;
    pick = -1;
    @(negedge clk);
    if (rstn) begin
      pick = m_idle ? model_pick() : -1;
      chk("req_ready", 32'(req_ready), (pick >= 0) ? (32'd1 << pick) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      if (m_resp) begin
        chk("rsp_id",   32'(rsp_id),   32'(e_id));
        chk("rsp_sum",  32'(rsp_sum),  32'(e_sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(e_cout));
      end
      if (rsp_valid && rsp_ready) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_sums.push_back(int'(rsp_sum));
        rsp_couts.push_back(int'(rsp_cout));
      end
      if (pick >= 0) begin
        a      = int'(req_a[pick*N +: N]);
        b      = int'(req_b[pick*N +: N]);
        e_id   = pick;
        e_sum  = (a + b) % (1 << N);
        e_cout = ((a + b) >= (1 << N)) ? 1 : 0;
        m_idle = 1'b0;
        m_lat  = 2;
        m_ptr  = pick;
        grants.push_back(pick);
        grant_cyc.push_back(cyc);
      end else if (m_resp) begin
        if (rsp_ready) begin
          m_resp = 1'b0;
          m_idle = 1'b1;
        end
      end else if (!m_idle) begin
        m_lat--;
        if (m_lat == 0) m_resp = 1'b1;
      end
    end else begin
      m_idle = 1'b1;
      m_resp = 1'b0;
      m_ptr  = R - 1;
    end
    last_pick = pick;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int a, input int b);
    req_valid[id]    = 1'b1;
    req_a[id*N +: N] = N'(a);
    req_b[id*N +: N] = N'(b);
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    cycle();
    rstn = 1'b1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    chk("rst_rsp_cout",  32'(rsp_cout),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic run_single(input int id, input int a, input int b);
    rsp_ready = 1'b1;
    set_req(id, a, b);
    cycle();
    if (last_pick == id) req_valid[id] = 1'b0;
    for (int k = 0; k < 12 && !m_idle; k++) cycle();
    req_valid[id] = 1'b0;
  endtask

  initial begin
    int n0, r0;
    bit saw_id1;
    rstn      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_idle    = 1'b1;
    m_resp    = 1'b0;
    m_lat     = 0;
    m_ptr     = R - 1;
    e_id = 0; e_sum = 0; e_cout = 0;
    last_pick = -1;

    cycle();
    do_reset();

    // Single request from requester 2
    run_single(2, 43, 25);
    chk("t1_grant", 32'(grants[$]), 32'd2);
    chk("t1_id",    32'(rsp_ids[$]),   32'd2);
    chk("t1_sum",   32'(rsp_sums[$]),  32'd4);
    chk("t1_cout",  32'(rsp_couts[$]), 32'd1);

    // All four valid from reset: strict rotation, one grant per 4 cycles
    do_reset();
    grants.delete();
    grant_cyc.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < R; i++) set_req(i, $urandom_range(0, 63), $urandom_range(0, 63));
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_pick >= 0) set_req(last_pick, $urandom_range(0, 63), $urandom_range(0, 63));
    end
    req_valid = '0;
    chk("t2_count", 32'(grants.size()), 32'd5);
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      chk("t2_order", 32'(grants[k]), 32'(k % R));
      if (k > 0) chk("t2_gap", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd4);
    end

    // Backpressure: stall 5 cycles in RESP while another requester waits
    rsp_ready = 1'b0;
    set_req(1, 17, 30);
    cycle();
    req_valid[1] = 1'b0;
    cycle();
    cycle();
    chk("t3_in_resp", 32'(rsp_valid), 32'd1);
    set_req(0, 5, 9);
    repeat (5) cycle();
    rsp_ready = 1'b1;
    cycle();
    cycle();
    chk("t3_regrant", 32'(grants[$]), 32'd0);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 12 && !m_idle; k++) cycle();

    // Edge operands
    run_single(0, 63, 1);
    chk("t4a_sum", 32'(rsp_sums[$]), 32'd0);  chk("t4a_cout", 32'(rsp_couts[$]), 32'd1);
    run_single(0, 0, 0);
    chk("t4b_sum", 32'(rsp_sums[$]), 32'd0);  chk("t4b_cout", 32'(rsp_couts[$]), 32'd0);
    run_single(0, 63, 63);
    chk("t4c_sum", 32'(rsp_sums[$]), 32'd62); chk("t4c_cout", 32'(rsp_couts[$]), 32'd1);
    run_single(0, 3, 1);
    chk("t4d_sum", 32'(rsp_sums[$]), 32'd4);  chk("t4d_cout", 32'(rsp_couts[$]), 32'd0);

    // Reset during PH2, then pointer restarts at R-1
    rsp_ready = 1'b1;
    set_req(2, 10, 20);
    cycle();
    req_valid[2] = 1'b0;
    cycle();
    do_reset();
    n0 = grants.size();
    set_req(1, 7, 8);
    set_req(3, 60, 9);
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_pick >= 0) req_valid[last_pick] = 1'b0;
    end
    chk("t5_first",  32'(grants[n0]),   32'd1);
    chk("t5_second", 32'(grants[n0+1]), 32'd3);

    // Requester 1 drops valid before being granted
    r0 = rsp_ids.size();
    set_req(0, 1, 2);
    cycle();
    req_valid[0] = 1'b0;
    set_req(1, 11, 12);
    set_req(2, 13, 14);
    cycle();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_pick >= 0) req_valid[last_pick] = 1'b0;
    end
    chk("t6_grant", 32'(grants[$]), 32'd2);
    saw_id1 = 1'b0;
    for (int k = r0; k < rsp_ids.size(); k++) if (rsp_ids[k] == 1) saw_id1 = 1'b1;
    chk("t6_no_id1", 32'(saw_id1), 32'd0);

    // Randomized traffic with random backpressure and occasional drops
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < R; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, $urandom_range(0, 63), $urandom_range(0, 63));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      cycle();
      if (last_pick >= 0) req_valid[last_pick] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
